// File: rtl/pool_tmr_scheduler.sv
// pool_tmr_scheduler: time-shares two checker PEs and one backup PE across the
// lanes of pool layers 1 and 2. Each cycle one (layer, lane) is granted to the
// checkers; two cycles later the checker and primary results are majority-voted.
// The first disagreeing (layer, lane) is latched, drives the backup PE and the
// primary-lane disables, and is skipped by the lane rotation until cleared.
module pool_tmr_scheduler #(
  parameter int DW     = 16,
  parameter int NLANES = 3,
  parameter int LW     = 3,
  parameter int CW     = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              vld1,
  input  logic              vld2,
  input  logic              fault_clear,
  input  logic [DW-1:0]     chk_res_a,
  input  logic [DW-1:0]     chk_res_b,
  input  logic [DW-1:0]     prim_res,
  output logic              chk_en,
  output logic              chk_layer,
  output logic [LW-1:0]     chk_lane,
  output logic              fault_valid,
  output logic              fault_layer,
  output logic [LW-1:0]     fault_lane,
  output logic [NLANES-1:0] lane_dis1,
  output logic [NLANES-1:0] lane_dis2,
  output logic              bkp_en,
  output logic [CW-1:0]     err_cnt
);

  // Next lane index with wrap from NLANES-1 back to 0.
  function automatic logic [LW-1:0] lane_inc(input logic [LW-1:0] x);
    if (x == LW'(NLANES - 1)) begin
      return '0;
    end
    return x + LW'(1);
  endfunction

  // Per-layer rotation pointers.
  logic [LW-1:0] ptr1_q, ptr1_d;
  logic [LW-1:0] ptr2_q, ptr2_d;

  // Stage 1: tag of the grant issued in the previous cycle.
  logic          t1_vld_q, t1_vld_d;
  logic          t1_layer_q, t1_layer_d;
  logic [LW-1:0] t1_lane_q, t1_lane_d;

  // Stage 2: tag plus the three results belonging to it.
  logic          t2_vld_q, t2_vld_d;
  logic          t2_layer_q, t2_layer_d;
  logic [LW-1:0] t2_lane_q, t2_lane_d;
  logic [DW-1:0] res_a_q, res_a_d;
  logic [DW-1:0] res_b_q, res_b_d;
  logic [DW-1:0] res_p_q, res_p_d;

  // Sticky fault record and post-fault mismatch counter.
  logic          fault_valid_q, fault_valid_d;
  logic          fault_layer_q, fault_layer_d;
  logic [LW-1:0] fault_lane_q, fault_lane_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;

  // Grant decode results.
  logic          grant_en;
  logic          grant_layer;
  logic [LW-1:0] ptr_sel;
  logic          skip_lane;
  logic [LW-1:0] grant_lane;

  // Vote results for the check completing this cycle.
  logic [DW-1:0] vote;
  logic          mismatch;

  // Layer arbitration (layer 2 wins) and lane choice, stepping over a faulty lane.
  always_comb begin
    grant_en    = vld1 | vld2;
    grant_layer = vld2;
    ptr_sel     = vld2 ? ptr2_q : ptr1_q;
    skip_lane   = fault_valid_q && (fault_layer_q == grant_layer) &&
                  (fault_lane_q == ptr_sel);
    grant_lane  = skip_lane ? lane_inc(ptr_sel) : ptr_sel;
  end

  assign chk_en    = grant_en;
  assign chk_layer = grant_en & grant_layer;
  assign chk_lane  = grant_en ? grant_lane : '0;

  // Only the granted layer's pointer advances; it moves past the lane just checked.
  always_comb begin
    ptr1_d = ptr1_q;
    ptr2_d = ptr2_q;
    if (grant_en) begin
      if (grant_layer) begin
        ptr2_d = lane_inc(grant_lane);
      end else begin
        ptr1_d = lane_inc(grant_lane);
      end
    end
  end

  // Tag and result pipeline: results arrive one cycle after the grant.
  always_comb begin
    t1_vld_d   = grant_en;
    t1_layer_d = grant_layer;
    t1_lane_d  = grant_lane;
    t2_vld_d   = t1_vld_q;
    t2_layer_d = t1_layer_q;
    t2_lane_d  = t1_lane_q;
    res_a_d    = chk_res_a;
    res_b_d    = chk_res_b;
    res_p_d    = prim_res;
  end

  // Bitwise two-of-three vote; the primary is wrong if it differs from the vote.
  always_comb begin
    vote     = (res_a_q & res_b_q) | (res_a_q & res_p_q) | (res_b_q & res_p_q);
    mismatch = t2_vld_q && (res_p_q != vote);
  end

  // Fault capture: first mismatch is latched, later ones are counted; clear wins.
  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_layer_d = fault_layer_q;
    fault_lane_d  = fault_lane_q;
    err_cnt_d     = err_cnt_q;
    if (fault_clear) begin
      fault_valid_d = 1'b0;
      fault_layer_d = 1'b0;
      fault_lane_d  = '0;
      err_cnt_d     = '0;
    end else if (mismatch) begin
      if (!fault_valid_q) begin
        fault_valid_d = 1'b1;
        fault_layer_d = t2_layer_q;
        fault_lane_d  = t2_lane_q;
      end else if (err_cnt_q != {CW{1'b1}}) begin
        err_cnt_d = err_cnt_q + CW'(1);
      end
    end
  end

  // State registers; reset drops any in-flight checks along with the fault record.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ptr1_q        <= '0;
      ptr2_q        <= '0;
      t1_vld_q      <= 1'b0;
      t1_layer_q    <= 1'b0;
      t1_lane_q     <= '0;
      t2_vld_q      <= 1'b0;
      t2_layer_q    <= 1'b0;
      t2_lane_q     <= '0;
      res_a_q       <= '0;
      res_b_q       <= '0;
      res_p_q       <= '0;
      fault_valid_q <= 1'b0;
      fault_layer_q <= 1'b0;
      fault_lane_q  <= '0;
      err_cnt_q     <= '0;
    end else begin
      ptr1_q        <= ptr1_d;
      ptr2_q        <= ptr2_d;
      t1_vld_q      <= t1_vld_d;
      t1_layer_q    <= t1_layer_d;
      t1_lane_q     <= t1_lane_d;
      t2_vld_q      <= t2_vld_d;
      t2_layer_q    <= t2_layer_d;
      t2_lane_q     <= t2_lane_d;
      res_a_q       <= res_a_d;
      res_b_q       <= res_b_d;
      res_p_q       <= res_p_d;
      fault_valid_q <= fault_valid_d;
      fault_layer_q <= fault_layer_d;
      fault_lane_q  <= fault_lane_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign fault_valid = fault_valid_q;
  assign fault_layer = fault_layer_q;
  assign fault_lane  = fault_lane_q;
  assign err_cnt     = err_cnt_q;
  assign bkp_en      = fault_valid_q & (fault_layer_q ? vld2 : vld1);

  // One disable bit per lane, set only for the recorded faulty lane of its layer.
  for (genvar gi = 0; gi < NLANES; gi++) begin : g_dis
    assign lane_dis1[gi] = fault_valid_q & ~fault_layer_q & (fault_lane_q == LW'(gi));
    assign lane_dis2[gi] = fault_valid_q &  fault_layer_q & (fault_lane_q == LW'(gi));
  end

endmodule
